// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and port-slicing helpers for the multi-port register file
package regfile_pkg;

    localparam int ZERO_REG = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Base bit index of read-side port p inside a flattened bus of field width w.
    function automatic int rd_slice(input int port, input int width);
        return port * width;
    endfunction

    // Base bit index of write-side port w inside a flattened bus of field width w.
    function automatic int wr_slice(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - decode/writeback bundle of the multi-port register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int NUMREGS   = 32,
    parameter int DATAWIDTH = 32,
    parameter int NUMRD     = 2,
    parameter int NUMWR     = 1
);
    localparam int ADDRW = clog2(NUMREGS);

    logic [NUMRD-1:0]           re_i;
    logic [NUMRD*ADDRW-1:0]     raddr_i;
    logic [NUMRD*DATAWIDTH-1:0] rdata_o;
    logic [NUMRD-1:0]           rbusy_o;
    logic [NUMWR-1:0]           we_i;
    logic [NUMWR*ADDRW-1:0]     waddr_i;
    logic [NUMWR*DATAWIDTH-1:0] wdata_i;
    logic                       iss_i;
    logic [ADDRW-1:0]           iss_addr_i;
    logic [NUMREGS-1:0]         busy_o;

    modport master (
        output re_i, raddr_i, we_i, waddr_i, wdata_i, iss_i, iss_addr_i,
        input  rdata_o, rbusy_o, busy_o
    );

    modport slave (
        input  re_i, raddr_i, we_i, waddr_i, wdata_i, iss_i, iss_addr_i,
        output rdata_o, rbusy_o, busy_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write busy bits, set on issue and cleared on writeback
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUMREGS = 32,
    parameter int NUMWR   = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUMWR-1:0]                    we_i,
    input  logic [NUMWR*clog2(NUMREGS)-1:0]     waddr_i,
    input  logic                                iss_i,
    input  logic [clog2(NUMREGS)-1:0]           iss_addr_i,
    output logic [NUMREGS-1:0]                  busy_o
);
    localparam int ADDRW = clog2(NUMREGS);

    logic [NUMREGS-1:0] busy_q;
    logic [NUMREGS-1:0] busy_d;
    logic [ADDRW-1:0]   clr_addr;

    always_comb begin
        busy_d   = busy_q;
        clr_addr = '0;
        for (int w = 0; w < NUMWR; w++) begin
            clr_addr = waddr_i[wr_slice(w, ADDRW) +: ADDRW];
            if (we_i[w]) begin
                busy_d[clr_addr] = 1'b0;
            end
        end
        // Set is applied after clear: a same-cycle issue is a newer producer still in flight.
        if (iss_i) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with hazard scoreboard; same-cycle forwarding under REGFILE_BYPASS_EN
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NUMREGS   = 32,
    parameter int DATAWIDTH = 32,
    parameter int NUMRD     = 2,
    parameter int NUMWR     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    regfile_mp_if.slave rf
);
    localparam int ADDRW = clog2(NUMREGS);

    logic [DATAWIDTH-1:0]       mem_q [NUMREGS];
    logic [DATAWIDTH-1:0]       mem_d [NUMREGS];
    logic [NUMREGS-1:0]         busy;
    logic [NUMRD*DATAWIDTH-1:0] rdata;
    logic [NUMRD-1:0]           rbusy;
    logic [ADDRW-1:0]           wa;
    logic [ADDRW-1:0]           ra;

    regfile_scoreboard #(
        .NUMREGS (NUMREGS),
        .NUMWR   (NUMWR)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (rf.we_i),
        .waddr_i    (rf.waddr_i),
        .iss_i      (rf.iss_i),
        .iss_addr_i (rf.iss_addr_i),
        .busy_o     (busy)
    );

    // Ascending port order makes the highest-index writer win on an address collision.
    always_comb begin
        mem_d = mem_q;
        wa    = '0;
        for (int w = 0; w < NUMWR; w++) begin
            wa = rf.waddr_i[wr_slice(w, ADDRW) +: ADDRW];
            if (rf.we_i[w] && wa != ADDRW'(ZERO_REG)) begin
                mem_d[wa] = rf.wdata_i[wr_slice(w, DATAWIDTH) +: DATAWIDTH];
            end
        end
        mem_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUMREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int p = 0; p < NUMRD; p++) begin
            ra = rf.raddr_i[rd_slice(p, ADDRW) +: ADDRW];
            if (rf.re_i[p] && ra != ADDRW'(ZERO_REG)) begin
                rdata[rd_slice(p, DATAWIDTH) +: DATAWIDTH] = mem_q[ra];
                rbusy[p] = busy[ra];
`ifdef REGFILE_BYPASS_EN
                // Forwarded data is already here, so the consumer need not stall on it.
                for (int w = 0; w < NUMWR; w++) begin
                    if (rf.we_i[w] && rf.waddr_i[wr_slice(w, ADDRW) +: ADDRW] == ra) begin
                        rdata[rd_slice(p, DATAWIDTH) +: DATAWIDTH] =
                            rf.wdata_i[wr_slice(w, DATAWIDTH) +: DATAWIDTH];
                        rbusy[p] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign rf.rdata_o = rdata;
    assign rf.rbusy_o = rbusy;
    assign rf.busy_o  = busy;

endmodule
